// File: rtl/heichips25_tile_driver.sv
// Host-side pin transactor for a heichips25 tiny tile: sequences rst_n/ena,
// drives ui/uio, waits a programmable settle time and returns sampled outputs.
module heichips25_tile_driver #(
    parameter int RST_CYCLES = 8,
    parameter int HOLD_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_tile_reset,
    input  logic [7:0]        cmd_ui,
    input  logic [7:0]        cmd_uio,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [7:0]        cmd_exp,
    input  logic [7:0]        cmd_exp_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_uo,
    output logic [7:0]        rsp_uio,
    output logic [7:0]        rsp_oe,
    output logic              rsp_mismatch,
    output logic              tile_rst_n,
    output logic              tile_ena,
    output logic [7:0]        tile_ui_in,
    output logic [7:0]        tile_uio_in,
    input  logic [7:0]        tile_uo_out,
    input  logic [7:0]        tile_uio_out,
    input  logic [7:0]        tile_uio_oe,
    output logic              busy,
    output logic [15:0]       err_count
);

    localparam logic [1:0] S_TRST = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // One counter serves both the reset-low count and the settle count.
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int CNT_W = (HOLD_W > RST_W) ? HOLD_W : RST_W;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trst_cmd_q, trst_cmd_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       mask_q, mask_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_uo_q, rsp_uo_d;
    logic [7:0]       rsp_uio_q, rsp_uio_d;
    logic [7:0]       rsp_oe_q, rsp_oe_d;
    logic             rsp_mismatch_q, rsp_mismatch_d;
    logic             tile_rst_n_q, tile_rst_n_d;
    logic             tile_ena_q, tile_ena_d;
    logic [7:0]       tile_ui_q, tile_ui_d;
    logic [7:0]       tile_uio_q, tile_uio_d;
    logic             busy_q, busy_d;
    logic [15:0]      err_q, err_d;
    logic             mismatch;

    assign mismatch = |((tile_uo_out ^ exp_q) & mask_q);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        trst_cmd_d     = trst_cmd_q;
        exp_d          = exp_q;
        mask_d         = mask_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_uo_d       = rsp_uo_q;
        rsp_uio_d      = rsp_uio_q;
        rsp_oe_d       = rsp_oe_q;
        rsp_mismatch_d = rsp_mismatch_q;
        tile_rst_n_d   = tile_rst_n_q;
        tile_ena_d     = 1'b1;
        tile_ui_d      = tile_ui_q;
        tile_uio_d     = tile_uio_q;
        err_d          = err_q;

        case (state_q)
            S_TRST: begin
                tile_rst_n_d = 1'b0;
                tile_ui_d    = 8'h00;
                tile_uio_d   = 8'h00;
                if (cnt_q == CNT_W'(RST_CYCLES)) begin
                    tile_rst_n_d = 1'b1;
                    if (trst_cmd_q) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_uo_d       = 8'h00;
                        rsp_uio_d      = 8'h00;
                        rsp_oe_d       = 8'h00;
                        rsp_mismatch_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    exp_d      = cmd_exp;
                    mask_d     = cmd_exp_mask;
                    trst_cmd_d = cmd_tile_reset;
                    if (cmd_tile_reset) begin
                        // The handshake edge already counts as the first low cycle.
                        state_d      = S_TRST;
                        cnt_d        = CNT_W'(1);
                        tile_rst_n_d = 1'b0;
                        tile_ui_d    = 8'h00;
                        tile_uio_d   = 8'h00;
                    end else begin
                        state_d    = S_WAIT;
                        cnt_d      = CNT_W'(cmd_hold);
                        tile_ui_d  = cmd_ui;
                        tile_uio_d = cmd_uio;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d        = S_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_uo_d       = tile_uo_out;
                    rsp_uio_d      = tile_uio_out & tile_uio_oe;
                    rsp_oe_d       = tile_uio_oe;
                    rsp_mismatch_d = mismatch;
                    if (mismatch && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_TRST;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_TRST;
            cnt_q          <= '0;
            trst_cmd_q     <= 1'b0;
            exp_q          <= 8'h00;
            mask_q         <= 8'h00;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_uo_q       <= 8'h00;
            rsp_uio_q      <= 8'h00;
            rsp_oe_q       <= 8'h00;
            rsp_mismatch_q <= 1'b0;
            tile_rst_n_q   <= 1'b0;
            tile_ena_q     <= 1'b0;
            tile_ui_q      <= 8'h00;
            tile_uio_q     <= 8'h00;
            busy_q         <= 1'b1;
            err_q          <= 16'h0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            trst_cmd_q     <= trst_cmd_d;
            exp_q          <= exp_d;
            mask_q         <= mask_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_uo_q       <= rsp_uo_d;
            rsp_uio_q      <= rsp_uio_d;
            rsp_oe_q       <= rsp_oe_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            tile_rst_n_q   <= tile_rst_n_d;
            tile_ena_q     <= tile_ena_d;
            tile_ui_q      <= tile_ui_d;
            tile_uio_q     <= tile_uio_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_uo       = rsp_uo_q;
    assign rsp_uio      = rsp_uio_q;
    assign rsp_oe       = rsp_oe_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign tile_rst_n   = tile_rst_n_q;
    assign tile_ena     = tile_ena_q;
    assign tile_ui_in   = tile_ui_q;
    assign tile_uio_in  = tile_uio_q;
    assign busy         = busy_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_heichips25_tile_driver.sv
// Directed bench for heichips25_tile_driver against a loopback tile model
// (uo_out = ui_in + 1) with a response scoreboard.
module tb_heichips25_tile_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_tile_reset = 1'b0;
    logic [7:0]  cmd_ui = 8'h00;
    logic [7:0]  cmd_uio = 8'h00;
    logic [7:0]  cmd_hold = 8'h00;
    logic [7:0]  cmd_exp = 8'h00;
    logic [7:0]  cmd_exp_mask = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_uo, rsp_uio, rsp_oe;
    logic        rsp_mismatch;
    logic        tile_rst_n, tile_ena;
    logic [7:0]  tile_ui_in, tile_uio_in;
    logic [7:0]  tile_uo_out;
    logic [7:0]  tile_uio_out = 8'h00;
    logic [7:0]  tile_uio_oe = 8'h00;
    logic        busy;
    logic [15:0] err_count;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
        logic       mm;
    } rsp_t;

    rsp_t sb[$];
    rsp_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_err = 0;

    assign tile_uo_out = tile_ui_in + 8'd1;

    always #5 clk = ~clk;

    heichips25_tile_driver #(.RST_CYCLES(8), .HOLD_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tile_reset(cmd_tile_reset),
        .cmd_ui(cmd_ui), .cmd_uio(cmd_uio), .cmd_hold(cmd_hold),
        .cmd_exp(cmd_exp), .cmd_exp_mask(cmd_exp_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uo(rsp_uo), .rsp_uio(rsp_uio),
        .rsp_oe(rsp_oe), .rsp_mismatch(rsp_mismatch),
        .tile_rst_n(tile_rst_n), .tile_ena(tile_ena), .tile_ui_in(tile_ui_in),
        .tile_uio_in(tile_uio_in), .tile_uo_out(tile_uo_out), .tile_uio_out(tile_uio_out),
        .tile_uio_oe(tile_uio_oe), .busy(busy), .err_count(err_count)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, 16'(cmd_ready), 16'h0);
        checkOutput({tag, "_rsp_valid"}, 16'(rsp_valid), 16'h0);
        checkOutput({tag, "_rsp_data"}, {rsp_uo, rsp_uio | rsp_oe}, 16'h0);
        checkOutput({tag, "_rsp_mismatch"}, 16'(rsp_mismatch), 16'h0);
        checkOutput({tag, "_tile_ctl"}, {14'h0, tile_rst_n, tile_ena}, 16'h0);
        checkOutput({tag, "_tile_pins"}, {tile_ui_in, tile_uio_in}, 16'h0);
        checkOutput({tag, "_busy"}, 16'(busy), 16'h1);
        checkOutput({tag, "_err_count"}, err_count, 16'h0);
    endtask

    // Releases rst on a falling edge and measures the tile reset-low window.
    task automatic releaseAndCheckTrst(input string tag);
        int low;
        low = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ena_first"}, 16'(tile_ena), 16'h1);
        while (!tile_rst_n && low < 50) begin
            low++;
            checkOutput({tag, "_ready_low"}, 16'(cmd_ready), 16'h0);
            @(negedge clk);
        end
        checkOutput({tag, "_low_cycles"}, 16'(low), 16'd8);
        checkOutput({tag, "_ready_rise"}, 16'(cmd_ready), 16'h1);
    endtask

    task automatic applyStimulus(input logic tr, input logic [7:0] ui, input logic [7:0] uio,
                                 input logic [7:0] hold, input logic [7:0] expv, input logic [7:0] mask);
        rsp_t r;
        logic [7:0] uo_model;
        @(negedge clk);
        checkOutput("cmd_ready_idle", 16'(cmd_ready), 16'h1);
        cmd_valid = 1'b1;
        cmd_tile_reset = tr;
        cmd_ui = ui;
        cmd_uio = uio;
        cmd_hold = hold;
        cmd_exp = expv;
        cmd_exp_mask = mask;
        if (tr) begin
            r.uo = 8'h00; r.uio = 8'h00; r.oe = 8'h00; r.mm = 1'b0;
        end else begin
            uo_model = ui + 8'd1;
            r.uo  = uo_model;
            r.uio = tile_uio_out & tile_uio_oe;
            r.oe  = tile_uio_oe;
            r.mm  = |((uo_model ^ expv) & mask);
            if (r.mm) exp_err++;
        end
        sb.push_back(r);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_tile_reset = 1'b0;
        checkOutput("ready_after_hs", 16'(cmd_ready), 16'h0);
        if (tr) begin
            checkOutput("trst_pins", {tile_ui_in, tile_uio_in}, 16'h0);
        end else begin
            checkOutput("pins_driven", {tile_ui_in, tile_uio_in}, {ui, uio});
        end
    endtask

    task automatic waitResp(input int exp_lat);
        int lat;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rsp_latency", 16'(lat), 16'(exp_lat));
    endtask

    task automatic checkResponse();
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 16'h0, 16'h1);
        end else begin
            cur = sb.pop_front();
            checkOutput("rsp_valid", 16'(rsp_valid), 16'h1);
            checkOutput("rsp_uo", 16'(rsp_uo), 16'(cur.uo));
            checkOutput("rsp_uio", 16'(rsp_uio), 16'(cur.uio));
            checkOutput("rsp_oe", 16'(rsp_oe), 16'(cur.oe));
            checkOutput("rsp_mismatch", 16'(rsp_mismatch), 16'(cur.mm));
            checkOutput("err_count", err_count, 16'(exp_err));
        end
    endtask

    task automatic ackResp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", 16'(rsp_valid), 16'h0);
        checkOutput("ready_after_ack", 16'(cmd_ready), 16'h1);
        checkOutput("busy_idle", 16'(busy), 16'h0);
    endtask

    initial begin
        // Power-on reset and the initial tile reset sequence
        repeat (2) @(negedge clk);
        checkResetValues("por");
        releaseAndCheckTrst("por");

        // Loopback compare: match, masked mismatch, fully masked
        applyStimulus(1'b0, 8'h41, 8'h00, 8'd0, 8'h42, 8'hFF);
        waitResp(2);
        checkResponse();
        ackResp();
        applyStimulus(1'b0, 8'h41, 8'h00, 8'd0, 8'h00, 8'h0F);
        waitResp(2);
        checkResponse();
        ackResp();
        applyStimulus(1'b0, 8'h41, 8'h00, 8'd0, 8'h00, 8'h00);
        waitResp(2);
        checkResponse();
        ackResp();

        // Bidirectional pins with a settle time
        tile_uio_oe  = 8'hF0;
        tile_uio_out = 8'hAB;
        applyStimulus(1'b0, 8'h10, 8'h5C, 8'd5, 8'h11, 8'hFF);
        waitResp(7);
        checkResponse();
        ackResp();

        // Backpressure with an ignored command pulse
        applyStimulus(1'b0, 8'h80, 8'h3C, 8'd2, 8'h81, 8'hFF);
        waitResp(4);
        checkResponse();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_valid = (i == 4);
            cmd_ui = (i == 4) ? 8'h77 : 8'h80;
            checkOutput("bp_valid", 16'(rsp_valid), 16'h1);
            checkOutput("bp_uo", 16'(rsp_uo), 16'(cur.uo));
            checkOutput("bp_uio", {rsp_uio, rsp_oe}, {cur.uio, cur.oe});
            checkOutput("bp_ready", 16'(cmd_ready), 16'h0);
        end
        cmd_valid = 1'b0;
        ackResp();
        checkOutput("bp_pins_kept", {tile_ui_in, tile_uio_in}, 16'h803C);

        // Reset during the settle wait discards the pending response
        applyStimulus(1'b0, 8'h22, 8'h33, 8'd20, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        sb.delete();
        exp_err = 0;
        @(negedge clk);
        releaseAndCheckTrst("midrst");

        // Tile reset command: eight low cycles then an all-zero response
        begin
            int low;
            applyStimulus(1'b1, 8'hFF, 8'hFF, 8'd9, 8'hFF, 8'hFF);
            low = 1;
            while (!tile_rst_n && low < 50) begin
                checkOutput("cmd_trst_pins", {tile_ui_in, tile_uio_in}, 16'h0);
                @(negedge clk);
                if (!tile_rst_n) low++;
            end
            checkOutput("cmd_trst_low", 16'(low), 16'd8);
            checkOutput("cmd_trst_ena", 16'(tile_ena), 16'h1);
            checkResponse();
            ackResp();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/heichips25_tile_driver.md
Name: heichips25_tile_driver

Overview:
- Host-side pin transactor for a heichips25 tiny tile, i.e. the block that sits on the other side of the tile's ui/uio/uo pins.
- It generates the tile's rst_n/ena sequence, applies commanded ui_in/uio_in values, and waits a programmable number of cycles.
- It then samples uo_out/uio_out/uio_oe and returns them with an optional masked compare result.
- Used to drive any tile project (wrapper or individual project) from an on-chip sequencer or a bench.

Parameters:
- RST_CYCLES, 8: tile_rst_n low cycles after reset or after a tile-reset command (must be ≥1).
- HOLD_W, 8: width of the per-command settle count.

Ports:
- clk  in  1  single clock; the tile runs on the same clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accept.
- cmd_tile_reset  in  1  1 = rerun the tile reset sequence instead of a pin drive.
- cmd_ui  in  8  value for tile_ui_in.
- cmd_uio  in  8  value for tile_uio_in.
- cmd_hold  in  HOLD_W  extra settle cycles before sampling.
- cmd_exp  in  8  expected uo_out.
- cmd_exp_mask  in  8  compare mask for uo_out (1 = compare this bit).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_uo  out  8  sampled tile_uo_out.
- rsp_uio  out  8  sampled tile_uio_out & tile_uio_oe.
- rsp_oe  out  8  sampled tile_uio_oe.
- rsp_mismatch  out  1  masked compare failed.
- tile_rst_n  out  1  to tile rst_n.
- tile_ena  out  1  to tile ena.
- tile_ui_in  out  8  to tile ui_in.
- tile_uio_in  out  8  to tile uio_in.
- tile_uo_out  in  8  from tile.
- tile_uio_out  in  8  from tile.
- tile_uio_oe  in  8  from tile.
- busy  out  1  state != IDLE.
- err_count  out  16  saturating count of mismatching responses.

Behaviour:
- All outputs are registered. Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_*=0, rsp_mismatch=0.
  - tile_rst_n=0, tile_ena=0, tile_ui_in=0, tile_uio_in=0.
  - busy=1, err_count=0.
- FSM states: TRST, IDLE, WAIT, RESP.
- TRST:
  - tile_ena=1 from the first cycle after rst deasserts.
  - tile_rst_n=0 for exactly RST_CYCLES cycles, then tile_rst_n=1 and the FSM enters IDLE.
  - tile_ui_in and tile_uio_in are forced to 0 while in TRST.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready at edge T) latches the whole command and clears cmd_ready.
- Pin-drive command:
  - tile_ui_in and tile_uio_in take the commanded values at edge T, so they are visible in cycle T+1.
  - WAIT lasts cmd_hold+1 cycles.
  - tile_uo_out, tile_uio_out and tile_uio_oe are sampled at the edge ending cycle T+1+cmd_hold.
  - rsp_valid=1 from cycle T+2+cmd_hold. With hold=0, rsp_valid rises 2 cycles after the handshake.
- Tile-reset command (cmd_tile_reset=1):
  - Enters TRST (RST_CYCLES cycles low); pins go to 0.
  - Then RESP with rsp_uo/uio/oe=0 and rsp_mismatch=0.
  - cmd_ui, cmd_uio and cmd_hold are ignored.
- Compare:
  - rsp_mismatch = |((tile_uo_out ^ cmd_exp) & cmd_exp_mask). Mask 0 means never a mismatch.
  - err_count increments on the sampling edge when mismatch=1 and saturates at 16'hFFFF.
- rsp_uio masks non-output bits to 0. tile_uio_in is driven with cmd_uio on all bits regardless of oe; the tile ignores its input bits where oe=1.
- RESP:
  - rsp_valid and rsp_* are held stable until rsp_ready.
  - On handshake: rsp_valid=0, FSM → IDLE, and cmd_ready=1 in the next cycle. There is no back-to-back overlap, so throughput is at most one command per hold+3 cycles.
- Pins keep their last driven values between commands. Only TRST changes them to 0.
- cmd_hold=max (2^HOLD_W−1) gives 2^HOLD_W WAIT cycles; the counter has no wrap issue.
- cmd_valid while busy is ignored; no command is queued.
- rst asserted mid-operation: all outputs return immediately (asynchronously) to their reset values. Any pending response is discarded, and the TRST sequence reruns after deassertion.

Test Plan:
- Reset sequence, RST_CYCLES=8: release rst → tile_ena=1 the next cycle; tile_rst_n low exactly 8 cycles, then high; cmd_ready=1 in the same cycle tile_rst_n rises.
- Loopback tile (uo_out = ui_in + 1), hold=0: cmd_ui=8'h41, exp=8'h42, mask=8'hFF → rsp_uo=8'h42, mismatch=0, rsp_valid 2 cycles after the handshake.
- Same tile with exp=8'h00, mask=8'h0F → mismatch=1, err_count=1. Repeat with mask=8'h00 → mismatch=0 and err_count stays 1.
- Tile with uio_oe=8'hF0 and uio_out=8'hAB, hold=5 → rsp_oe=8'hF0, rsp_uio=8'hA0, rsp_valid 7 cycles after the handshake.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_* stable, cmd_ready=0 throughout, and a cmd_valid pulse is ignored. After the rsp handshake, cmd_ready=1 the next cycle.
- Mid-operation reset: assert rst during WAIT → all outputs at reset values in the same cycle; after release, a full 8-cycle TRST occurs. Separately, a cmd_tile_reset command yields 8 cycles of tile_rst_n=0 and then a response with all-zero data.
